// File: rtl/phold.sv
// phold: single-core PHOLD event engine. Pops the earliest pending event, logs it
// through one MC write port, then reschedules that slot with an LFSR-derived delay.
module phold #(
  parameter int NUM_MC_PORTS    = 1,
  parameter int SIM_END_TIME    = 1000,
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int TIME_WID        = 16,
  parameter int NUM_LP          = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [47:0]                addr,
  output logic [TIME_WID-1:0]        gvt,
  output logic                       rtn_vld,
  output logic                       mc_rq_vld,
  output logic [2:0]                 mc_rq_cmd,
  output logic [3:0]                 mc_rq_scmd,
  output logic [47:0]                mc_rq_vadr,
  output logic [1:0]                 mc_rq_size,
  output logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  output logic [63:0]                mc_rq_data,
  output logic                       mc_rq_flush,
  input  logic                       mc_rq_stall,
  input  logic                       mc_rs_vld,
  input  logic [2:0]                 mc_rs_cmd,
  input  logic [3:0]                 mc_rs_scmd,
  input  logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  input  logic [63:0]                mc_rs_data,
  output logic                       mc_rs_stall
);

  localparam int LP_W = $clog2(NUM_LP);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [TIME_WID-1:0] TIME_MAX = '1;

  typedef enum logic [1:0] {
    SELECT,
    WRITE,
    WAIT_RSP,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [TIME_WID-1:0] q_time [NUM_LP];
  logic [LP_W-1:0]     q_lp   [NUM_LP];
  logic [15:0]         lfsr;

  logic [LP_W-1:0]     sel_idx;
  logic [TIME_WID-1:0] sel_time;
  logic [LP_W-1:0]     sel_lp;

  logic [LP_W-1:0]     min_idx;
  logic [TIME_WID-1:0] min_time;
  logic                min_at_end;
  logic                accept;

  logic [TIME_WID:0]   time_sum;
  logic [TIME_WID-1:0] new_time;
  logic [LP_W-1:0]     new_lp;
  logic [15:0]         lfsr_next;

  // Strict less-than keeps the lowest index on equal timestamps.
  always_comb begin
    min_idx  = '0;
    min_time = q_time[0];
    for (int i = 1; i < NUM_LP; i++) begin
      if (q_time[i] < min_time) begin
        min_idx  = LP_W'(i);
        min_time = q_time[i];
      end
    end
  end

  assign min_at_end = 32'(min_time) >= 32'(SIM_END_TIME);

  // The delay is always at least 1, so a rescheduled event never lands at or before gvt.
  assign time_sum  = {1'b0, sel_time} + (TIME_WID+1)'(lfsr[4:0]) + (TIME_WID+1)'(1);
  assign new_time  = time_sum[TIME_WID] ? TIME_MAX : time_sum[TIME_WID-1:0];
  assign new_lp    = lfsr[LP_W+4:5];
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SELECT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    mc_rq_vld  = 1'b0;
    rtn_vld    = 1'b0;
    accept     = 1'b0;
    case (state)
      SELECT: begin
        next_state = min_at_end ? DONE : WRITE;
      end
      WRITE: begin
        mc_rq_vld = 1'b1;
        if (!mc_rq_stall) begin
          accept     = 1'b1;
          next_state = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mc_rs_vld) begin
          next_state = SELECT;
        end
      end
      DONE: begin
        rtn_vld = 1'b1;
      end
      default: begin
        next_state = SELECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LP; i++) begin
        q_time[i] <= TIME_WID'(i);
        q_lp[i]   <= LP_W'(i);
      end
      lfsr     <= LFSR_SEED;
      gvt      <= '0;
      sel_idx  <= '0;
      sel_time <= '0;
      sel_lp   <= '0;
    end else begin
      if (state == SELECT) begin
        gvt <= min_time;
        if (!min_at_end) begin
          sel_idx  <= min_idx;
          sel_time <= min_time;
          sel_lp   <= q_lp[min_idx];
        end
      end
      if (accept) begin
        q_time[sel_idx] <= new_time;
        q_lp[sel_idx]   <= new_lp;
        lfsr            <= lfsr_next;
      end
    end
  end

  // Request fields come only from the latched event, so they hold steady under stall.
  assign mc_rq_cmd    = 3'd2;
  assign mc_rq_scmd   = 4'd0;
  assign mc_rq_size   = 2'd3;
  assign mc_rq_flush  = 1'b0;
  assign mc_rs_stall  = 1'b0;
  assign mc_rq_vadr   = addr + {{(48-LP_W-3){1'b0}}, sel_lp, 3'b000};
  assign mc_rq_data   = {{(64-LP_W-TIME_WID){1'b0}}, sel_lp, sel_time};
  assign mc_rq_rtnctl = {{(MC_RTNCTL_WIDTH-LP_W){1'b0}}, sel_lp};

  logic unused_inputs;
  assign unused_inputs = ^{mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data, NUM_MC_PORTS[0]};

endmodule

// File: tb/tb_phold.sv
// tb_phold: directed bench with an event-level PHOLD model compared every cycle,
// plus a second instance whose end time is 0.
module tb_phold;

  localparam int TIME_WID = 16;
  localparam int NUM_LP   = 8;
  localparam int RTN_W    = 32;
  localparam int END_T    = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [47:0] addr = '0;
  logic mc_rq_stall = 1'b0;
  logic mc_rs_vld = 1'b0;
  logic [2:0] mc_rs_cmd = 3'd3;
  logic [3:0] mc_rs_scmd = 4'd0;
  logic [RTN_W-1:0] mc_rs_rtnctl = '0;
  logic [63:0] mc_rs_data = '0;

  logic [TIME_WID-1:0] gvt;
  logic rtn_vld, mc_rq_vld, mc_rq_flush, mc_rs_stall;
  logic [2:0] mc_rq_cmd;
  logic [3:0] mc_rq_scmd;
  logic [47:0] mc_rq_vadr;
  logic [1:0] mc_rq_size;
  logic [RTN_W-1:0] mc_rq_rtnctl;
  logic [63:0] mc_rq_data;

  logic [TIME_WID-1:0] gvt_z;
  logic rtn_vld_z, rq_vld_z, rq_flush_z, rs_stall_z;
  logic [2:0] rq_cmd_z;
  logic [3:0] rq_scmd_z;
  logic [47:0] rq_vadr_z;
  logic [1:0] rq_size_z;
  logic [RTN_W-1:0] rq_rtnctl_z;
  logic [63:0] rq_data_z;

  int n_checks = 0;
  int n_errors = 0;
  int acc_count = 0;
  int inject_req = 0;
  int rsp_delay = 3;

  int m_time [NUM_LP];
  int m_lp   [NUM_LP];
  logic [15:0] m_lfsr = 16'hACE1;
  int m_last = 0;

  always #5 clk = ~clk;

  phold #(
    .NUM_MC_PORTS(1), .SIM_END_TIME(END_T), .MC_RTNCTL_WIDTH(RTN_W),
    .TIME_WID(TIME_WID), .NUM_LP(NUM_LP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .gvt(gvt), .rtn_vld(rtn_vld),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall)
  );

  phold #(
    .NUM_MC_PORTS(1), .SIM_END_TIME(0), .MC_RTNCTL_WIDTH(RTN_W),
    .TIME_WID(TIME_WID), .NUM_LP(NUM_LP)
  ) dut_end0 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .gvt(gvt_z), .rtn_vld(rtn_vld_z),
    .mc_rq_vld(rq_vld_z), .mc_rq_cmd(rq_cmd_z), .mc_rq_scmd(rq_scmd_z),
    .mc_rq_vadr(rq_vadr_z), .mc_rq_size(rq_size_z), .mc_rq_rtnctl(rq_rtnctl_z),
    .mc_rq_data(rq_data_z), .mc_rq_flush(rq_flush_z), .mc_rq_stall(1'b0),
    .mc_rs_vld(1'b0), .mc_rs_cmd(3'd3), .mc_rs_scmd(4'd0),
    .mc_rs_rtnctl('0), .mc_rs_data(64'd0), .mc_rs_stall(rs_stall_z)
  );

  logic unused_z;
  assign unused_z = ^{rq_cmd_z, rq_scmd_z, rq_vadr_z, rq_size_z, rq_rtnctl_z, rq_data_z};

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_LP; i++) begin
      m_time[i] = i;
      m_lp[i]   = i;
    end
    m_lfsr = 16'hACE1;
    m_last = 0;
  endtask

  function automatic int head_idx();
    int b = 0;
    for (int i = 1; i < NUM_LP; i++) begin
      if (m_time[i] < m_time[b]) b = i;
    end
    return b;
  endfunction

  task automatic model_accept(input int h);
    int nt;
    m_last = m_time[h];
    nt = m_time[h] + 1 + int'(m_lfsr[4:0]);
    if (nt > (1 << TIME_WID) - 1) nt = (1 << TIME_WID) - 1;
    m_time[h] = nt;
    m_lp[h]   = int'(m_lfsr[7:5]);
    m_lfsr    = lfsr_step(m_lfsr);
  endtask

  // Compare process: every negedge, DUT outputs against the event-level model.
  always @(negedge clk) begin
    int h;
    if (!rst_n) begin
      model_reset();
      check_output("rst_gvt", 64'(gvt), 64'd0);
      check_output("rst_rtn_vld", 64'(rtn_vld), 64'd0);
      check_output("rst_rq_vld", 64'(mc_rq_vld), 64'd0);
      check_output("rst_flush", 64'(mc_rq_flush), 64'd0);
      check_output("rst_rs_stall", 64'(mc_rs_stall), 64'd0);
      check_output("rst_end0_rtn", 64'(rtn_vld_z), 64'd0);
    end else begin
      h = head_idx();
      check_output("flush", 64'(mc_rq_flush), 64'd0);
      check_output("rs_stall", 64'(mc_rs_stall), 64'd0);
      check_output("end0_no_req", 64'(rq_vld_z), 64'd0);
      check_output("end0_flush", 64'(rq_flush_z | rs_stall_z), 64'd0);
      if (mc_rq_vld) begin
        check_output("req_rtn_vld", 64'(rtn_vld), 64'd0);
        check_output("req_cmd", 64'(mc_rq_cmd), 64'd2);
        check_output("req_scmd", 64'(mc_rq_scmd), 64'd0);
        check_output("req_size", 64'(mc_rq_size), 64'd3);
        check_output("req_vadr", 64'(mc_rq_vadr), 64'(addr + 48'(m_lp[h] * 8)));
        check_output("req_data", mc_rq_data, 64'(m_lp[h]) * 64'd65536 + 64'(m_time[h]));
        check_output("req_rtnctl", 64'(mc_rq_rtnctl), 64'(m_lp[h]));
        check_output("req_gvt", 64'(gvt), 64'(m_time[h]));
        check_output("req_before_end", 64'(m_time[h] < END_T), 64'd1);
        if (addr == 48'h1000) begin
          check_output("req_vadr_range", 64'((mc_rq_vadr >= 48'h1000) &&
                       (mc_rq_vadr <= 48'h1038) && (mc_rq_vadr[2:0] == 3'd0)), 64'd1);
        end
        if (!mc_rq_stall) begin
          model_accept(h);
          acc_count++;
        end
      end else if (rtn_vld) begin
        check_output("done_min_ge_end", 64'(m_time[h] >= END_T), 64'd1);
        check_output("done_gvt", 64'(gvt), 64'(m_time[h]));
      end else begin
        check_output("idle_gvt", 64'(gvt), 64'(m_last));
      end
    end
  end

  // Memory responder: write-complete rsp_delay cycles after each acceptance.
  initial begin
    int cnt;
    int seen;
    int inj_done;
    cnt = 0;
    seen = 0;
    inj_done = 0;
    forever begin
      @(posedge clk);
      #1;
      mc_rs_vld = 1'b0;
      if (!rst_n) begin
        cnt  = 0;
        seen = acc_count;
      end else begin
        if (seen != acc_count) begin
          seen = acc_count;
          cnt  = rsp_delay;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) mc_rs_vld = 1'b1;
        end
        if (inj_done != inject_req) begin
          inj_done  = inject_req;
          mc_rs_vld = 1'b1;
        end
      end
    end
  end

  task automatic wait_req(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = mc_rq_vld;
    end
    check_output({name, "_arrived"}, 64'(seen), 64'd1);
  endtask

  task automatic wait_accepts(input int n, input int budget);
    int target;
    target = acc_count + n;
    for (int k = 0; k < budget && acc_count < target; k++) begin
      @(negedge clk);
    end
    check_output("accepts_reached", 64'(acc_count >= target), 64'd1);
  endtask

  initial begin
    int acc0;
    bit done;
    rst_n = 1'b0;
    addr = 48'h0;
    mc_rq_stall = 1'b0;
    rsp_delay = 3;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check_output("select_no_req", 64'(mc_rq_vld), 64'd0);
    check_output("end0_select_rtn", 64'(rtn_vld_z), 64'd0);
    @(negedge clk);
    check_output("end0_done_rtn", 64'(rtn_vld_z), 64'd1);
    check_output("end0_done_gvt", 64'(gvt_z), 64'd0);
    check_output("ev1_vld", 64'(mc_rq_vld), 64'd1);
    check_output("ev1_vadr", 64'(mc_rq_vadr), 64'h0);
    check_output("ev1_data", mc_rq_data, 64'h0);
    check_output("ev1_rtnctl", 64'(mc_rq_rtnctl), 64'h0);
    check_output("ev1_cmd", 64'(mc_rq_cmd), 64'd2);
    check_output("ev1_size", 64'(mc_rq_size), 64'd3);
    #1;
    check_output("model_ev1_time", 64'(m_time[0]), 64'd2);
    check_output("model_ev1_lp", 64'(m_lp[0]), 64'd7);
    check_output("model_ev1_lfsr", 64'(m_lfsr), 64'hE270);

    wait_req(20, "ev2");
    check_output("ev2_vadr", 64'(mc_rq_vadr), 64'h8);
    check_output("ev2_data", mc_rq_data, 64'h10001);
    check_output("ev2_rtnctl", 64'(mc_rq_rtnctl), 64'h1);
    check_output("ev2_gvt", 64'(gvt), 64'd1);
    #1;
    check_output("model_ev2_time", 64'(m_time[1]), 64'd18);
    check_output("model_ev2_lp", 64'(m_lp[1]), 64'd3);
    check_output("model_ev2_lfsr", 64'(m_lfsr), 64'h7138);

    // Tie between slots 0 and 2 at time 2, presented under a 5-cycle stall.
    @(posedge clk);
    #1 mc_rq_stall = 1'b1;
    wait_req(20, "ev3");
    check_output("ev3_vadr", 64'(mc_rq_vadr), 64'h38);
    check_output("ev3_data", mc_rq_data, 64'h70002);
    check_output("ev3_rtnctl", 64'(mc_rq_rtnctl), 64'h7);
    check_output("ev3_gvt", 64'(gvt), 64'd2);
    acc0 = acc_count;
    inject_req++;
    repeat (4) begin
      @(negedge clk);
      check_output("stall_hold_vld", 64'(mc_rq_vld), 64'd1);
    end
    @(posedge clk);
    #1 mc_rq_stall = 1'b0;
    repeat (3) @(negedge clk);
    check_output("stall_one_accept", 64'(acc_count - acc0), 64'd1);
    check_output("model_ev3_time", 64'(m_time[0]), 64'd27);
    check_output("model_ev3_lp", 64'(m_lp[0]), 64'd1);

    wait_accepts(30, 600);

    // Asynchronous reset while a request is being presented.
    @(posedge clk);
    #1 mc_rq_stall = 1'b1;
    wait_req(50, "pre_reset");
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_vld", 64'(mc_rq_vld), 64'd0);
    check_output("async_rst_gvt", 64'(gvt), 64'd0);
    check_output("async_rst_end0_rtn", 64'(rtn_vld_z), 64'd0);
    @(posedge clk);
    #1;
    mc_rq_stall = 1'b0;
    addr = 48'h1000;
    rsp_delay = 1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    acc0 = acc_count;
    done = 1'b0;
    for (int k = 0; k < 20000 && !done; k++) begin
      @(negedge clk);
      done = rtn_vld;
    end
    check_output("full_run_done", 64'(done), 64'd1);
    check_output("full_run_gvt_ge_end", 64'(int'(gvt) >= END_T), 64'd1);
    check_output("full_run_accepts", 64'((acc_count - acc0) > 100), 64'd1);
    check_output("end0_still_done", 64'(rtn_vld_z), 64'd1);
    repeat (20) begin
      @(negedge clk);
      check_output("done_stays", 64'(rtn_vld), 64'd1);
      check_output("done_no_req", 64'(mc_rq_vld), 64'd0);
    end

    #2 rst_n = 1'b0;
    #1;
    check_output("final_rst_rtn", 64'(rtn_vld), 64'd0);
    check_output("final_rst_gvt", 64'(gvt), 64'd0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
